// File: rtl/pwm_pkg.sv
// pwm_pkg: frame state encoding and channel/duty constants shared by the PWM
// generator and its SIPO output stage.
package pwm_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_OVERRUN} frame_state_e;
  localparam int PWM_CH = 8;
  localparam int DUTY_W = 8;
endpackage

// File: rtl/pwm_shift_core.sv
// pwm_shift_core: serial shift register, saturating bit counter and frame state;
// exposes the post-shift view so a same-cycle latch sees the closing bit.
module pwm_shift_core
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_CH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             s_in,
  input  logic             latch,
  output logic [WIDTH-1:0] sreg_post,
  output frame_state_e     state_post,
  output logic [CNT_W-1:0] bit_count
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  logic [WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0] cnt_q, cnt_post, cnt_d;
  frame_state_e state_q, state_d;
  always_comb begin
    sreg_post = shift_en ? {s_in, sreg_q[WIDTH-1:1]} : sreg_q;
    cnt_post = (shift_en && cnt_q != FULL_CNT) ? cnt_q + 1'b1 : cnt_q;
    state_post = !shift_en ? state_q :
                 (state_q == ST_FULL || state_q == ST_OVERRUN) ? ST_OVERRUN :
                 (cnt_post == FULL_CNT) ? ST_FULL : ST_FILLING;
    cnt_d = latch ? '0 : cnt_post;
    state_d = latch ? ST_EMPTY : state_post;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q <= '0;
      state_q <= ST_EMPTY;
    end else begin
      sreg_q <= sreg_post;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  assign bit_count = cnt_q;
endmodule

// File: rtl/pwm_sipo_latch.sv
// pwm_sipo_latch: latches serial PWM frames atomically onto registered outputs.
// Define PWM_FRAME_CHECK_EN to reject latches of incomplete or overrun frames.
module pwm_sipo_latch
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_CH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             s_in,
  input  logic             latch,
  input  logic             out_en,
  output logic [WIDTH-1:0] pwm,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] bit_count
);
`ifdef PWM_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif
  logic [WIDTH-1:0] sreg_post, hold_q, hold_d, pwm_q;
  frame_state_e state_post;
  logic accept, reject, fv_q, fe_q;
  pwm_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .reset(reset),
    .shift_en(shift_en),
    .s_in(s_in),
    .latch(latch),
    .sreg_post(sreg_post),
    .state_post(state_post),
    .bit_count(bit_count)
  );
  assign accept = latch && (!FRAME_CHECK || state_post == ST_FULL);
  assign reject = latch && !accept;
  assign hold_d = accept ? sreg_post : hold_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      pwm_q <= '0;
      fv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      pwm_q <= out_en ? hold_q : '0;
      fv_q <= accept;
      fe_q <= reject;
    end
  end
  assign pwm = pwm_q;
  assign frame_valid = fv_q;
  assign frame_err = fe_q;
endmodule

// File: doc/pwm_sipo_latch.md
Name: pwm_sipo_latch

Overview:
- Serial-in, parallel-out output stage directly downstream of the PWM generator.
- Each clock, the generator produces one duty-comparison bit per channel, serially, plus a latch strobe once per frame. This block shifts those bits in and counts them.
- On latch, it transfers the frame atomically to the registered pwm outputs, so all channels update on the same edge.
- It detects malformed frames and can gate its outputs.

Parameters:
- WIDTH, 8, number of PWM channels (bits per frame); legal range is 2 to 64.
- CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; clears all state on the posedge where it is sampled high.
- shift_en  input  1  qualifies s_in; one bit is shifted per cycle when high.
- s_in  input  1  serial channel bit; the first bit of a frame is channel 0.
- latch  input  1  frame-transfer strobe, one cycle wide.
- out_en  input  1  when low, forces pwm to 0; internal registers keep updating.
- pwm  output  WIDTH  registered parallel PWM outputs; pwm[i] is channel i.
- frame_valid  output  1  one-cycle pulse; the cycle after an accepted latch.
- frame_err  output  1  one-cycle pulse; the cycle after a rejected latch (see Optional Feature).
- bit_count  output  CNT_W  current number of bits shifted into the open frame.

Behaviour:
- Reset values: shift register 0, hold register 0, pwm 0, bit_count 0, frame_valid 0, frame_err 0, state EMPTY.
- Shift direction:
  - On shift_en, sreg <= {s_in, sreg[WIDTH-1:1]}.
  - After WIDTH shifts, the first bit sits at sreg[0].
- Bit counter:
  - Increments on shift_en and saturates at WIDTH.
  - A shift while already full does not increment the counter; it sets the overrun state.
- States:
  - EMPTY: bit_count == 0.
  - FILLING: 0 < bit_count < WIDTH.
  - FULL: bit_count == WIDTH.
  - OVERRUN: a shift occurred while FULL.
- Transitions:
  - EMPTY->FILLING on shift.
  - FILLING->FULL on the WIDTH-th shift.
  - FULL->OVERRUN on shift.
  - Any state->EMPTY on latch or reset.
- Latch acceptance:
  - A latch is accepted if the post-shift state of that cycle is FULL.
  - If shift_en and latch are both high, the shifted bit belongs to the closing frame; the latch captures the post-shift sreg value.
- Accepted latch:
  - hold <= post-shift sreg, bit_count <= 0, sreg is not cleared.
  - frame_valid = 1 on the next cycle.
- Output timing:
  - pwm = out_en ? hold : 0, registered.
  - Latency: pwm reflects the new frame one cycle after the latch edge.
- Gating:
  - out_en deassertion takes effect on the next edge.
  - Re-assertion restores the current hold value without needing a new latch.
- latch with no shift since the last latch (EMPTY): treated as incomplete (see Optional Feature).
- Reset mid-frame:
  - Discards the partial frame; pwm goes to 0 on the next edge.
  - A latch coincident with reset is ignored.
- frame_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: PWM_FRAME_CHECK_EN.
- Defined:
  - A latch in EMPTY, FILLING or OVERRUN is rejected.
  - On a rejected latch: hold and pwm keep their previous value; bit_count <= 0; state -> EMPTY; frame_err pulses for one cycle; frame_valid stays 0.
- Not defined:
  - Every latch is accepted and transfers the current sreg regardless of count.
  - frame_valid pulses on every latch.
  - frame_err is tied to 0; the OVERRUN state is still tracked for bit_count saturation.

Decomposition:
- Shared package pwm_pkg:
  - state encoding typedef (EMPTY, FILLING, FULL, OVERRUN);
  - default channel count constant PWM_CH = 8;
  - duty-table width constant, shared with the generator.
- One sub-module, pwm_shift_core: sreg, bit counter and state machine.
- The top level holds the hold register, output gating and the pulse outputs.

Test Plan:
- Nominal frame:
  - Stimulus: WIDTH=8, out_en=1; shift bits 1,0,1,1,0,0,0,1; then latch the next cycle.
  - Response: pwm = 8'h8D (pwm[0]=1) one cycle after latch; frame_valid pulses once; bit_count returns to 0.
- Simultaneous shift and latch:
  - Stimulus: 7 shifts of 1, then an 8th shift of 0 with latch high in the same cycle.
  - Response: pwm = 8'h7F; frame_valid pulses.
- Short frame, PWM_FRAME_CHECK_EN defined:
  - Stimulus: after a valid frame 8'hA5, shift 5 bits, then latch.
  - Response: pwm stays 8'hA5; frame_err pulses; bit_count = 0.
  - Stimulus: same, with the macro undefined.
  - Response: pwm updates to the sreg contents; frame_err stays 0.
- Overrun:
  - Stimulus: 9 shifts, then latch, with the check enabled.
  - Response: bit_count saturates at 8; frame_err pulses; pwm unchanged.
- Gating:
  - Stimulus: load 8'h3C; drop out_en for 4 cycles; accept a new frame 8'hC3 during the gap; raise out_en.
  - Response: pwm = 0 during the gap; pwm = 8'hC3 one cycle after out_en rises.
- Reset mid-frame:
  - Stimulus: pwm = 8'hFF; shift 4 bits; assert reset for 1 cycle together with latch.
  - Response: pwm = 0, bit_count = 0, no frame_valid or frame_err pulse; the next full frame latches normally.
